// File: rtl/control_sequencer.sv
// Purpose : microcoded control sequencer driving the 16-bit control word of the 4-bit-address bus computer.
// Latency : ctrl is combinational from the current T-state; the step counter advances once per clk edge.
// Backpressure: none; the sequencer free-runs until HLT executes, then holds until clr_n is pulled low.
//
// Ports:
//   clk     rising-edge clock
//   clr_n   asynchronous active-low reset (clears step and halt; gates ctrl to 0 while low)
//   opcode  instruction register upper nibble
//   flag_c  registered carry flag (consulted by JC at T2 only)
//   flag_z  registered zero flag  (consulted by JZ at T2 only)
//   ctrl    control word {hlt,mi,ri,ro,io,ii,ai,ao,eo,su,bi,oi,ce,co,j,fi}
//   step    current T-state, 0-based
//   halted  high once HLT has executed
//
// Optional feature macro: CONTROL_SEQUENCER_EARLY_END_EN
//   When defined, an execute step (T2 or later) whose decoded word is zero
//   ends the instruction early: the next edge returns step to 0.

module control_sequencer #(
    parameter int NUM_STEPS = 5
) (
    input  logic        clk,
    input  logic        clr_n,
    input  logic [3:0]  opcode,
    input  logic        flag_c,
    input  logic        flag_z,
    output logic [15:0] ctrl,
    output logic [2:0]  step,
    output logic        halted
);

    // Control word bit positions
    localparam logic [15:0] HLT = 16'h8000;
    localparam logic [15:0] MI  = 16'h4000;
    localparam logic [15:0] RI  = 16'h2000;
    localparam logic [15:0] RO  = 16'h1000;
    localparam logic [15:0] IO  = 16'h0800;
    localparam logic [15:0] II  = 16'h0400;
    localparam logic [15:0] AI  = 16'h0200;
    localparam logic [15:0] AO  = 16'h0100;
    localparam logic [15:0] EO  = 16'h0080;
    localparam logic [15:0] SU  = 16'h0040;
    localparam logic [15:0] BI  = 16'h0020;
    localparam logic [15:0] OI  = 16'h0010;
    localparam logic [15:0] CE  = 16'h0008;
    localparam logic [15:0] CO  = 16'h0004;
    localparam logic [15:0] J   = 16'h0002;
    localparam logic [15:0] FI  = 16'h0001;

    // Opcodes
    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_STA = 4'h4;
    localparam logic [3:0] OP_LDI = 4'h5;
    localparam logic [3:0] OP_JMP = 4'h6;
    localparam logic [3:0] OP_JC  = 4'h7;
    localparam logic [3:0] OP_JZ  = 4'h8;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    localparam logic [2:0] LAST_STEP = 3'(NUM_STEPS - 1);

    logic [2:0]  step_nxt;
    logic        halted_nxt;
    logic [15:0] uword;      // microcode word before halt/reset gating

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            step   <= 3'd0;
            halted <= 1'b0;
        end else begin
            step   <= step_nxt;
            halted <= halted_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Microcode decode. Flags only matter at T2 because that is the only
    // step where the conditional jumps have a non-zero word.
    // ------------------------------------------------------------------
    always_comb begin
        uword = 16'h0000;
        case (step)
            3'd0: uword = CO | MI;
            3'd1: uword = RO | II | CE;
            3'd2: begin
                case (opcode)
                    OP_LDA, OP_ADD, OP_SUB, OP_STA: uword = IO | MI;
                    OP_LDI: uword = IO | AI;
                    OP_JMP: uword = IO | J;
                    OP_JC:  uword = flag_c ? (IO | J) : 16'h0000;
                    OP_JZ:  uword = flag_z ? (IO | J) : 16'h0000;
                    OP_OUT: uword = AO | OI;
                    OP_HLT: uword = HLT;
                    default: uword = 16'h0000;
                endcase
            end
            3'd3: begin
                case (opcode)
                    OP_LDA:         uword = RO | AI;
                    OP_ADD, OP_SUB: uword = RO | BI;
                    OP_STA:         uword = AO | RI;
                    default:        uword = 16'h0000;
                endcase
            end
            3'd4: begin
                case (opcode)
                    OP_ADD:  uword = EO | AI | FI;
                    OP_SUB:  uword = EO | AI | SU | FI;
                    default: uword = 16'h0000;
                endcase
            end
            default: uword = 16'h0000;
        endcase
    end

    // ------------------------------------------------------------------
    // Next-state logic. A word with hlt set freezes the step counter on
    // the edge that ends it; only clr_n releases the halt.
    // ------------------------------------------------------------------
    always_comb begin
        step_nxt   = step;
        halted_nxt = halted;
        if (!halted) begin
            if (uword[15]) begin
                halted_nxt = 1'b1;
            end else if (step == LAST_STEP) begin
                step_nxt = 3'd0;
`ifdef CONTROL_SEQUENCER_EARLY_END_EN
            end else if ((step >= 3'd2) && (uword == 16'h0000)) begin
                step_nxt = 3'd0;
`endif
            end else begin
                step_nxt = step + 3'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Output logic. Reset gating is combinational so the word drops to
    // zero the instant clr_n falls, without waiting for a clock.
    // ------------------------------------------------------------------
    always_comb begin
        if (!clr_n) begin
            ctrl = 16'h0000;
        end else if (halted) begin
            ctrl = HLT;
        end else begin
            ctrl = uword;
        end
    end

endmodule
